mem_tile_responder: RTL and testbench

// - Memory-side responder for the L1 tile bus: the far end of memAddr/memOpm/memDataOut/memOK.
// - Backs 128-bit tiles with a synchronous RAM and answers with READY/HOLD/OK/FAULT per bus rules.
// - Sits below the L1 arbiter; serves as the L2/bootstrap-RAM stand-in and as a bus-protocol checker.

---
 rtl/mem_tile_responder_pkg.sv | 37 +++
 rtl/mem_tile_ram.sv | 30 +++
 rtl/mem_tile_responder.sv | 127 ++++++++++++
 tb/tb_mem_tile_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_tile_responder_pkg.sv
// Shared definitions for the L1 tile-bus memory responder: bus codes, opm fields and fault codes.
package mem_tile_responder_pkg;

    localparam int unsigned TILE_BITS = 128;
    localparam int unsigned ADDR_W    = 48;
    localparam int unsigned OPM_W     = 16;
    localparam int unsigned CODE_W    = 16;
    localparam int unsigned CNT_W     = 4;

    localparam int unsigned OPM_STORE_BIT = 4;
    localparam int unsigned OPM_LOAD_BIT  = 3;

    localparam logic [1:0] UMEM_OK_READY = 2'd0;
    localparam logic [1:0] UMEM_OK_OK    = 2'd1;
    localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;
    localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

    localparam logic [1:0] UMEM_OPM_READY = 2'b00;
    localparam logic [1:0] OP_LOAD        = 2'b01;
    localparam logic [1:0] OP_STORE       = 2'b10;
    localparam logic [1:0] OP_SWAP        = 2'b11;

    localparam logic [CODE_W-1:0] MEMFLT_BUS    = 16'h8000;
    localparam logic [CODE_W-1:0] MEMFLT_NOSWAP = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        FLT  = 2'd3
    } respState_t;

    function automatic logic [TILE_BITS-1:0] faultTile(input logic [CODE_W-1:0] code);
        return {{(TILE_BITS - CODE_W){1'b0}}, code};
    endfunction

endpackage

// File: rtl/mem_tile_ram.sv
// Single-port synchronous tile RAM: one 128-bit tile per entry, 1-cycle registered read.
module mem_tile_ram
    import mem_tile_responder_pkg::*;
#(
    parameter int unsigned IDX_BITS = 12
) (
    input  logic                 clock,
    input  logic                 en,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  addr,
    input  logic [TILE_BITS-1:0] wrData,
    output logic [TILE_BITS-1:0] rdData
);

    localparam int unsigned DEPTH = 1 << IDX_BITS;

    logic [TILE_BITS-1:0] mem [DEPTH];

    // Contents are deliberately not reset so they survive a responder reset.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wrData;
            end else begin
                rdData <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_tile_responder.sv
// Memory-side responder for the L1 tile bus: request latch, latency FSM and protocol checker
// in front of a synchronous tile RAM.
module mem_tile_responder
    import mem_tile_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    memAddr,
    input  logic [ADDR_W-1:0]    memAddrB,
    input  logic [OPM_W-1:0]     memOpm,
    input  logic [TILE_BITS-1:0] memDataIn,
    output logic [TILE_BITS-1:0] memDataOut,
    output logic [1:0]           memOK,
    output logic                 protoErr
);

    localparam int unsigned IDX_BITS = ADDR_BITS - 4;

    respState_t           state;
    logic [CNT_W-1:0]     cnt;
    logic [ADDR_W-1:0]    reqAddr;
    logic [ADDR_W-1:0]    reqAddrB;
    logic [1:0]           reqOp;
    logic [TILE_BITS-1:0] reqData;

    logic [1:0]           opNow;
    logic                 addrFault_c;
    logic                 accept_c;
    logic                 protoViol_c;
    logic                 ramEn;
    logic                 ramWe;
    logic [IDX_BITS-1:0]  ramAddr;
    logic [TILE_BITS-1:0] ramRdData;
    logic                 unusedBits;

    assign opNow       = memOpm[OPM_STORE_BIT:OPM_LOAD_BIT];
    assign addrFault_c = (memAddr[ADDR_W-1:ADDR_BITS] != '0);
    assign accept_c    = (state == IDLE) && (opNow != UMEM_OPM_READY)
                         && !addrFault_c && (opNow != OP_SWAP);
    assign protoViol_c = (state != IDLE)
                         && (((opNow != UMEM_OPM_READY) && (opNow != reqOp)) || (memAddr != reqAddr));

    // Read starts at acceptance and repeats through BUSY, so the tile is ready at commit for any latency.
    assign ramEn   = accept_c || (state == BUSY);
    assign ramWe   = (state == BUSY) && (cnt == '0) && (reqOp == OP_STORE);
    assign ramAddr = (state == IDLE) ? memAddr[ADDR_BITS-1:4] : reqAddr[ADDR_BITS-1:4];

    // addrB is held for a future swap path; swaps currently fault before it is used.
    assign unusedBits = ^{reqAddrB, memOpm[OPM_W-1:OPM_STORE_BIT+1], memOpm[OPM_LOAD_BIT-1:0]};

    mem_tile_ram #(
        .IDX_BITS (IDX_BITS)
    ) uRam (
        .clock  (clock),
        .en     (ramEn),
        .we     (ramWe),
        .addr   (ramAddr),
        .wrData (reqData),
        .rdData (ramRdData)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            reqAddr    <= '0;
            reqAddrB   <= '0;
            reqOp      <= UMEM_OPM_READY;
            reqData    <= '0;
            memOK      <= UMEM_OK_READY;
            memDataOut <= '0;
            protoErr   <= 1'b0;
        end else begin
            if (protoViol_c) begin
                protoErr <= 1'b1;
            end
            case (state)
                IDLE: begin
                    memOK <= UMEM_OK_READY;
                    if (opNow != UMEM_OPM_READY) begin
                        reqAddr  <= memAddr;
                        reqAddrB <= memAddrB;
                        reqOp    <= opNow;
                        reqData  <= memDataIn;
                        if (addrFault_c) begin
                            state      <= FLT;
                            memOK      <= UMEM_OK_FAULT;
                            memDataOut <= faultTile(MEMFLT_BUS);
                        end else if (opNow == OP_SWAP) begin
                            state      <= FLT;
                            memOK      <= UMEM_OK_FAULT;
                            memDataOut <= faultTile(MEMFLT_NOSWAP);
                        end else begin
                            state <= BUSY;
                            memOK <= UMEM_OK_HOLD;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    memOK <= UMEM_OK_HOLD;
                    if (cnt == '0) begin
                        state      <= DONE;
                        memOK      <= UMEM_OK_OK;
                        memDataOut <= (reqOp == OP_STORE) ? reqData : ramRdData;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE, FLT: begin
                    if (opNow == UMEM_OPM_READY) begin
                        state <= IDLE;
                        memOK <= UMEM_OK_READY;
                    end
                end
                default: begin
                    state <= IDLE;
                    memOK <= UMEM_OK_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_tile_responder.sv
// Scoreboard bench for mem_tile_responder: driver pushes expected responses, monitor pops and compares.
module tb_mem_tile_responder;
    import mem_tile_responder_pkg::*;

    localparam int unsigned LAT = 2;
    localparam int unsigned AB  = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [47:0]    memAddr;
    logic [47:0]    memAddrB;
    logic [15:0]    memOpm;
    logic [127:0]   memDataIn;
    logic [127:0]   memDataOut;
    logic [1:0]     memOK;
    logic           protoErr;

    always #5 clock = ~clock;

    mem_tile_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .memAddr    (memAddr),
        .memAddrB   (memAddrB),
        .memOpm     (memOpm),
        .memDataIn  (memDataIn),
        .memDataOut (memDataOut),
        .memOK      (memOK),
        .protoErr   (protoErr)
    );

    typedef struct {
        logic [1:0]   ok;
        logic [127:0] data;
        int           holds;
    } expT;

    expT          expQ[$];
    logic [127:0] model [int];
    int           errors = 0;
    int           checks = 0;
    bit           expProto = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int pickTile();
        int k;
        k = int'($urandom_range(0, 34));
        if (k < 32) return k;
        if (k == 32) return 'h122;
        if (k == 33) return 'h123;
        return 'hFFF;
    endfunction

    // Monitor: the first cycle of OK/FAULT after READY/HOLD is one response.
    initial begin
        logic [1:0] prevOK;
        int         holds;
        expT        e;
        prevOK = UMEM_OK_READY;
        holds  = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prevOK = UMEM_OK_READY;
                holds  = 0;
            end else begin
                if (memOK == UMEM_OK_HOLD) holds++;
                else if (memOK == UMEM_OK_READY) holds = 0;
                else if (memOK != prevOK) begin
                    if (expQ.size() == 0) begin
                        check("unexpected response", 128'(memOK), 128'(UMEM_OK_READY));
                    end else begin
                        e = expQ.pop_front();
                        check("resp code", 128'(memOK), 128'(e.ok));
                        check("resp data", memDataOut, e.data);
                        check("hold cycles", 128'(holds), 128'(e.holds));
                    end
                end
                prevOK = memOK;
            end
        end
    end

    task automatic doReq(input logic [47:0] a, input logic [47:0] b, input logic [1:0] op,
                         input logic [127:0] d, input bit perturb);
        expT e;
        int  tile;
        bit  got;
        tile = int'(a[AB-1:4]);
        if (a[47:AB] != '0)     e = '{UMEM_OK_FAULT, {112'h0, 16'h8000}, 0};
        else if (op == 2'b11)   e = '{UMEM_OK_FAULT, 128'h0, 0};
        else if (op == 2'b10) begin
            e = '{UMEM_OK_OK, d, LAT};
            model[tile] = d;
        end else                e = '{UMEM_OK_OK, model[tile], LAT};
        expQ.push_back(e);
        memAddr   = a;
        memAddrB  = b;
        memOpm    = {11'($urandom), op, 3'($urandom)};
        memDataIn = d;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (perturb && i == 0) begin
                memAddr   = a ^ 48'h100;
                memDataIn = ~d;
                expProto  = 1'b1;
            end
            if (perturb && i == 1) memAddr = a;
            if (memOK == UMEM_OK_OK || memOK == UMEM_OK_FAULT) got = 1'b1;
        end
        if (!got) begin
            check("response timeout", 128'(memOK), 128'(e.ok));
            expQ.delete();
        end
        memOpm = '0;
        @(negedge clock);
        check("ready after drop", 128'(memOK), 128'(UMEM_OK_READY));
        check("protoErr", 128'(protoErr), 128'(expProto));
    endtask

    initial begin
        memAddr   = '0;
        memAddrB  = '0;
        memOpm    = '0;
        memDataIn = '0;
        repeat (3) @(negedge clock);
        check("reset memOK", 128'(memOK), 128'(UMEM_OK_READY));
        check("reset memDataOut", memDataOut, 128'h0);
        check("reset protoErr", 128'(protoErr), 128'h0);
        reset = 1'b0;

        // Give every tile the bench will touch a known value.
        for (int t = 0; t < 32; t++) doReq({32'h0, 12'(t), 4'h0}, 48'h0, 2'b10, rand128(), 1'b0);
        doReq(48'h1220, 48'h0, 2'b10, rand128(), 1'b0);
        doReq(48'h1230, 48'h0, 2'b10, rand128(), 1'b0);
        doReq(48'hFFF0, 48'h0, 2'b10, rand128(), 1'b0);

        // RAM persists across reset.
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        doReq(48'h40, 48'h0, 2'b01, 128'h0, 1'b0);

        doReq(48'h1230, 48'h0, 2'b10, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 1'b0);
        doReq(48'h1230, 48'h0, 2'b01, 128'h0, 1'b0);
        doReq(48'h1220, 48'h0, 2'b01, 128'h0, 1'b0);

        doReq(48'h0001_0000, 48'h0, 2'b01, 128'h0, 1'b0);
        doReq(48'h0001_0000, 48'h0, 2'b10, rand128(), 1'b0);
        doReq(48'h0, 48'h0, 2'b01, 128'h0, 1'b0);

        doReq(48'h1230, 48'h80, 2'b11, rand128(), 1'b0);
        doReq(48'h1230, 48'h0, 2'b01, 128'h0, 1'b0);
        doReq(48'h0080, 48'h0, 2'b01, 128'h0, 1'b0);

        doReq(48'hFFFF, 48'h0, 2'b10, rand128(), 1'b0);
        doReq(48'hFFF3, 48'h0, 2'b01, 128'h0, 1'b0);

        doReq(48'h1230, 48'h0, 2'b01, 128'h0, 1'b1);
        doReq(48'h0050, 48'h0, 2'b10, rand128(), 1'b1);
        doReq(48'h0050, 48'h0, 2'b01, 128'h0, 1'b0);

        // Reset during BUSY of a store: nothing is written, protoErr clears.
        memAddr   = 48'h1230;
        memAddrB  = '0;
        memOpm    = 16'h0010;
        memDataIn = rand128();
        @(negedge clock);
        check("hold before reset", 128'(memOK), 128'(UMEM_OK_HOLD));
        #2 reset = 1'b1;
        #1;
        check("async reset memOK", 128'(memOK), 128'(UMEM_OK_READY));
        check("async reset protoErr", 128'(protoErr), 128'h0);
        expProto = 1'b0;
        memOpm   = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        doReq(48'h1230, 48'h0, 2'b01, 128'h0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            int          r;
            logic [47:0] a;
            logic [47:0] b;
            logic [1:0]  op;
            r  = int'($urandom_range(0, 9));
            a  = {32'h0, 12'(pickTile()), 4'($urandom)};
            b  = {32'h0, 12'(pickTile()), 4'h0};
            op = (r < 4) ? 2'b10 : ((r == 9) ? 2'b11 : 2'b01);
            if (r == 0) a = a | (48'h1 << $urandom_range(AB, 47));
            doReq(a, b, op, rand128(), 1'b0);
        end

        repeat (2) @(negedge clock);
        check("scoreboard drained", 128'(expQ.size()), 128'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
